// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR LFSR generator/checker pair: default
// geometry, the next-word function both ends agree on, and the checker FSM
// state encoding.
package lfsr_pkg;

    // Default LFSR geometry.
    localparam int LFSR_WIDTH   = 14;
    localparam int LFSR_TAP_A   = 7;
    localparam int LFSR_TAP_B   = 2;

    // Widest word lfsr_next() can handle; callers zero-extend into this width
    // and truncate the result back to their own width.
    localparam int LFSR_MAX_W   = 32;

    // Checker synchronisation states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // next = {w[width-2:0], ~(w[tap_a] ^ w[tap_b])}, masked to 'width' bits.
    // XNOR feedback means the all-ones word maps onto itself (lock-up state).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] w,
        input int                    width,
        input int                    tap_a,
        input int                    tap_b
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
        fb   = ~(w[tap_a[4:0]] ^ w[tap_b[4:0]]);
        return {w[LFSR_MAX_W-2:0], fb} & mask;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker. Hunts for a seed word, verifies LOCK_COUNT
// consecutive predicted words, then free-runs its predictor (flywheel) and
// flags every word that disagrees. UNLOCK_COUNT consecutive misses while
// locked drop back to hunting.
//
// Interface: in_valid qualifies in_data for one cycle; there is no
// backpressure, so a word is accepted on every rising edge where in_valid=1.
// All outputs are registered and describe word N in the cycle after word N
// is sampled; cycles with in_valid=0 leave state untouched (pulses return to 0,
// clr_err still acts).
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH        = LFSR_WIDTH,
    parameter int TAP_A        = LFSR_TAP_A,
    parameter int TAP_B        = LFSR_TAP_B,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic             FPGA_CLK1_50,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic             sync_lost,
    output logic             lockup_seen,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       dbg_state
);

    localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_CNT_V   = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] UNLOCK_CNT_V = CNT_W'(UNLOCK_COUNT);
    localparam logic [WIDTH-1:0] ALL_ONES     = '1;
    localparam logic [ERR_W-1:0] ERR_MAX      = '1;

    // Registered state
    chk_state_t       r_state;
    logic [WIDTH-1:0] r_expected;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_locked;
    logic             r_mismatch;
    logic             r_sync_lost;
    logic             r_lockup_seen;
    logic [ERR_W-1:0] r_err_count;

    // Next-state signals
    chk_state_t       w_state_nxt;
    logic [WIDTH-1:0] w_expected_nxt;
    logic [CNT_W-1:0] w_match_nxt;
    logic [CNT_W-1:0] w_miss_nxt;
    logic             w_mismatch_nxt;
    logic             w_sync_lost_nxt;
    logic             w_err_inc;

    // Datapath helpers
    logic [WIDTH-1:0] w_pred_from_exp;
    logic [WIDTH-1:0] w_pred_from_in;
    logic             w_is_lockup;
    logic             w_hit;
    logic [CNT_W-1:0] w_match_inc;
    logic [CNT_W-1:0] w_miss_inc;

    assign w_pred_from_exp = WIDTH'(lfsr_next(LFSR_MAX_W'(r_expected), WIDTH, TAP_A, TAP_B));
    assign w_pred_from_in  = WIDTH'(lfsr_next(LFSR_MAX_W'(in_data), WIDTH, TAP_A, TAP_B));
    assign w_is_lockup     = (in_data == ALL_ONES);
    assign w_hit           = (in_data == r_expected);
    assign w_match_inc     = r_match_cnt + CNT_W'(1);
    assign w_miss_inc      = r_miss_cnt + CNT_W'(1);

    // Next-state, predictor and pulse decode for one accepted word.
    always_comb begin
        w_state_nxt     = r_state;
        w_expected_nxt  = r_expected;
        w_match_nxt     = r_match_cnt;
        w_miss_nxt      = r_miss_cnt;
        w_mismatch_nxt  = 1'b0;
        w_sync_lost_nxt = 1'b0;
        w_err_inc       = 1'b0;

        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    // An all-ones word cannot seed: its successor is itself.
                    if (!w_is_lockup) begin
                        w_expected_nxt = w_pred_from_in;
                        w_match_nxt    = '0;
                        w_state_nxt    = VERIFY;
                    end
                end

                VERIFY: begin
                    if (w_is_lockup) begin
                        // Lock-up word while verifying: count as a miss and hunt again.
                        w_mismatch_nxt = 1'b1;
                        w_match_nxt    = '0;
                        w_state_nxt    = HUNT;
                    end else if (w_hit) begin
                        w_expected_nxt = w_pred_from_exp;
                        w_match_nxt    = w_match_inc;
                        if (w_match_inc == LOCK_CNT_V) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        // Re-seed from the received word; errors before lock are not counted.
                        w_mismatch_nxt = 1'b1;
                        w_expected_nxt = w_pred_from_in;
                        w_match_nxt    = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: the predictor advances regardless of what arrived.
                    w_expected_nxt = w_pred_from_exp;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_mismatch_nxt = 1'b1;
                        w_err_inc      = 1'b1;
                        w_miss_nxt     = w_miss_inc;
                        if (w_miss_inc == UNLOCK_CNT_V) begin
                            w_state_nxt     = HUNT;
                            w_sync_lost_nxt = 1'b1;
                            w_miss_nxt      = '0;
                            w_match_nxt     = '0;
                        end
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                    w_match_nxt = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    // FSM, predictor and counters.
    always_ff @(posedge FPGA_CLK1_50 or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_mismatch  <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_mismatch  <= w_mismatch_nxt;
            r_sync_lost <= w_sync_lost_nxt;
        end
    end

    // Sticky lock-up flag: any accepted all-ones word, only reset clears it.
    always_ff @(posedge FPGA_CLK1_50 or posedge rst) begin
        if (rst) begin
            r_lockup_seen <= 1'b0;
        end else if (in_valid && w_is_lockup) begin
            r_lockup_seen <= 1'b1;
        end
    end

    // Saturating error counter; a clear in the same cycle as an increment wins.
    always_ff @(posedge FPGA_CLK1_50 or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign locked      = r_locked;
    assign mismatch    = r_mismatch;
    assign sync_lost   = r_sync_lost;
    assign lockup_seen = r_lockup_seen;
    assign err_count   = r_err_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker. Each accepted word pushes its expected
// output tuple {locked, mismatch, sync_lost, lockup_seen, err_count, state};
// a monitor pops and compares on the cycle the DUT presents the result.
// err_count is narrowed to 4 bits so saturation is reachable quickly.
module tb_lfsr_checker;

    localparam int W  = 14;
    localparam int EW = 4;
    localparam int XW = 6 + EW;

    localparam logic [1:0]    S_HUNT   = 2'd0;
    localparam logic [1:0]    S_VERIFY = 2'd1;
    localparam logic [1:0]    S_LOCKED = 2'd2;
    localparam logic [EW-1:0] E_MAX    = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          clr_err;
    logic          locked;
    logic          mismatch;
    logic          sync_lost;
    logic          lockup_seen;
    logic [EW-1:0] err_count;
    logic [1:0]    dbg_state;

    logic [XW-1:0] exp_q[$];
    int            n_vec  = 0;
    int            n_fail = 0;
    int            w_idx  = 0;
    logic          v_d;
    logic [W-1:0]  g;
    logic [W-1:0]  bad;
    logic [EW-1:0] e;
    logic [XW-1:0] mon_act;
    logic [XW-1:0] mon_exp;

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    lfsr_checker #(
        .WIDTH(14), .TAP_A(7), .TAP_B(2),
        .LOCK_COUNT(8), .UNLOCK_COUNT(3), .ERR_W(EW)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clr_err      (clr_err),
        .locked       (locked),
        .mismatch     (mismatch),
        .sync_lost    (sync_lost),
        .lockup_seen  (lockup_seen),
        .err_count    (err_count),
        .dbg_state    (dbg_state)
    );

    // Reference generator step, straight from the polynomial definition.
    function automatic logic [W-1:0] nx(input logic [W-1:0] w);
        return {w[W-2:0], ~(w[7] ^ w[2])};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp_v);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic lk, input logic mm, input logic sl,
                        input logic lu, input logic [EW-1:0] er, input logic [1:0] st);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back({lk, mm, sl, lu, er, st});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Async reset pulse raised between clock edges; outputs must clear at once.
    task automatic do_reset(input string name);
        idle(2);
        #3 rst = 1'b1;
        #1 check(name, {22'd0, locked, mismatch, sync_lost, lockup_seen, err_count, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) v_d <= 1'b0;
        else     v_d <= in_valid;
    end

    always @(negedge clk) begin
        if (v_d) begin
            mon_act = {locked, mismatch, sync_lost, lockup_seen, err_count, dbg_state};
            n_vec++;
            w_idx++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word %0d: output with no expected entry, got %h", w_idx, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL word %0d: got lk=%b mm=%b sl=%b lu=%b err=%0d st=%0d, want lk=%b mm=%b sl=%b lu=%b err=%0d st=%0d",
                             w_idx, mon_act[9], mon_act[8], mon_act[7], mon_act[6], mon_act[5:2], mon_act[1:0],
                             mon_exp[9], mon_exp[8], mon_exp[7], mon_exp[6], mon_exp[5:2], mon_exp[1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        clr_err  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {22'd0, locked, mismatch, sync_lost, lockup_seen, err_count, dbg_state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean stream from 0x0001, lock after seed + 8 matches.
        g = 14'h0001;
        for (int k = 0; k < 10; k++) begin
            send(g, k >= 8, 1'b0, 1'b0, 1'b0, 4'd0, (k >= 8) ? S_LOCKED : S_VERIFY);
            g = nx(g);
        end

        // 2: single corrupted word while locked; flywheel keeps matching afterwards.
        bad = (g == 14'h1234) ? 14'h1235 : 14'h1234;
        send(bad, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, S_LOCKED);
        g = nx(g);
        for (int k = 0; k < 3; k++) begin
            send(g, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, S_LOCKED);
            g = nx(g);
        end

        // 3: three consecutive misses drop lock, then relock on 9 clean words.
        send(g ^ 14'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, S_LOCKED); g = nx(g);
        send(g ^ 14'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, S_LOCKED); g = nx(g);
        send(g ^ 14'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, S_HUNT);   g = nx(g);
        for (int k = 0; k < 9; k++) begin
            send(g, k == 8, 1'b0, 1'b0, 1'b0, 4'd4, (k == 8) ? S_LOCKED : S_VERIFY);
            g = nx(g);
        end

        // Reset while locked with a non-zero error count.
        do_reset("async_rst_locked");

        // 4: all-ones words set the sticky flag and never seed or lock.
        send(14'h3FFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_HUNT);
        send(14'h3FFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_HUNT);
        send(14'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_VERIFY);
        send(14'h3FFF, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, S_HUNT);
        g = 14'h0005;
        for (int k = 0; k < 9; k++) begin
            send(g, k == 8, 1'b0, 1'b0, 1'b1, 4'd0, (k == 8) ? S_LOCKED : S_VERIFY);
            g = nx(g);
        end
        send(14'h3FFF, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, S_LOCKED);
        g = nx(g);
        do_reset("rst_clears_lockup");

        // 5: error counter saturation and clear priority.
        g = 14'h0100;
        for (int k = 0; k < 9; k++) begin
            send(g, k == 8, 1'b0, 1'b0, 1'b0, 4'd0, (k == 8) ? S_LOCKED : S_VERIFY);
            g = nx(g);
        end
        e = 4'd0;
        for (int r = 0; r < 9; r++) begin
            e = (e == E_MAX) ? E_MAX : e + 4'd1;
            send(g ^ 14'h0002, 1'b1, 1'b1, 1'b0, 1'b0, e, S_LOCKED); g = nx(g);
            e = (e == E_MAX) ? E_MAX : e + 4'd1;
            send(g ^ 14'h0002, 1'b1, 1'b1, 1'b0, 1'b0, e, S_LOCKED); g = nx(g);
            send(g, 1'b1, 1'b0, 1'b0, 1'b0, e, S_LOCKED); g = nx(g);
        end
        clr_err = 1'b1;
        send(g ^ 14'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, S_LOCKED); g = nx(g);
        clr_err = 1'b0;
        send(g ^ 14'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, S_LOCKED); g = nx(g);
        send(g, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, S_LOCKED); g = nx(g);
        idle(1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_idle", {28'd0, err_count}, 32'd0);
        check("idle_holds_lock", {31'd0, locked}, 32'd1);

        // 6: generator seeded 0x2A5C, gaps, re-seed in VERIFY, reset mid-VERIFY.
        do_reset("rst_before_gen");
        g = 14'h2A5C;
        send(14'h3FFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_HUNT);
        send(g, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_VERIFY); g = nx(g);
        idle(2);
        check("gap_holds_state", {29'd0, mismatch, dbg_state}, {29'd0, 1'b0, S_VERIFY});
        send(g, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_VERIFY); g = nx(g);
        idle(1);
        send(g ^ 14'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, S_VERIFY); g = nx(g);
        send(g, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, S_VERIFY); g = nx(g);
        idle(3);
        send(g, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, S_VERIFY); g = nx(g);
        do_reset("async_rst_verify");

        for (int k = 0; k < 9; k++) begin
            send(g, k == 8, 1'b0, 1'b0, 1'b0, 4'd0, (k == 8) ? S_LOCKED : S_VERIFY);
            g = nx(g);
            idle($urandom_range(0, 3));
        end
        send(g ^ 14'h0800, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, S_LOCKED); g = nx(g);
        idle(2);
        for (int k = 0; k < 3; k++) begin
            send(g, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, S_LOCKED);
            g = nx(g);
            idle($urandom_range(0, 2));
        end

        // ---------------- report ----------------
        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
